// File: rtl/avst_video_ctrl_packet_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : avst_video_ctrl_packet_decoder_if
// Description : Avalon-ST Video streaming interface. It carries 24-bit data
//               as three parallel 8-bit symbols, with symbol 0 in bits [7:0].
//               The master modport drives data, packet delimiters and valid,
//               and receives ready. The slave modport is the mirror image.
// Signals     : data[23:0], startofpacket, endofpacket, valid, ready
// Revision    : 1.0 - initial release
// ============================================================================
interface avst_video_ctrl_packet_decoder_if;
  logic [23:0] data;
  logic        startofpacket;
  logic        endofpacket;
  logic        valid;
  logic        ready;

  modport master (
    output data,
    output startofpacket,
    output endofpacket,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  startofpacket,
    input  endofpacket,
    input  valid,
    output ready
  );
endinterface
`default_nettype wire

// File: rtl/avst_video_ctrl_packet_decoder.sv
`default_nettype none
// ============================================================================
// Module      : avst_video_ctrl_packet_decoder
// Description : In-line monitor for an Avalon-ST Video stream. The stream
//               passes through combinationally and is not modified.
//               Control packets (type 0xF) are decoded into frame width,
//               frame height and the interlace nibble. Video packets
//               (type 0x0) are counted and reported as done or failed.
//               All status pulses are registered. They assert in the cycle
//               after the beat that causes them.
// Build macro : AVST_FRAME_CHECK_EN
//               - Defined: every video packet is checked against the
//                 committed width*height pixel count.
//               - Undefined: the pixel counter and the multiplier are left
//                 out. frame_done pulses on every video-packet end, and also
//                 when a video packet is aborted. frame_err is tied to 0.
// Ports       : clk, reset        - clock, asynchronous active-high reset
//               din  (slave)      - sink stream
//               dout (master)     - source stream (copy of din)
//               frame_width/height/interlace - committed geometry
//               ctrl_update/ctrl_err         - control packet status pulses
//               frame_done/frame_err         - video packet status pulses
//               frame_count                  - completed video packets
// Revision    : 1.0 - initial release
// ============================================================================
module avst_video_ctrl_packet_decoder #(
  parameter int unsigned DEFAULT_WIDTH  = 640,
  parameter int unsigned DEFAULT_HEIGHT = 480
) (
  input  logic                                    clk,
  input  logic                                    reset,
  avst_video_ctrl_packet_decoder_if.slave         din,
  avst_video_ctrl_packet_decoder_if.master        dout,
  output logic [15:0]                             frame_width,
  output logic [15:0]                             frame_height,
  output logic [3:0]                              frame_interlace,
  output logic                                    ctrl_update,
  output logic                                    ctrl_err,
  output logic                                    frame_done,
  output logic                                    frame_err,
  output logic [15:0]                             frame_count
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_CTRL    = 2'd1;
  localparam logic [1:0]  S_VIDEO   = 2'd2;
  localparam logic [1:0]  S_SKIP    = 2'd3;

  localparam logic [3:0]  HDR_CTRL  = 4'hF;
  localparam logic [3:0]  HDR_VIDEO = 4'h0;

  localparam logic [15:0] RST_WIDTH  = 16'(DEFAULT_WIDTH);
  localparam logic [15:0] RST_HEIGHT = 16'(DEFAULT_HEIGHT);
`ifdef AVST_FRAME_CHECK_EN
  localparam logic [31:0] RST_PIXELS = 32'(DEFAULT_WIDTH * DEFAULT_HEIGHT);
`endif

  // --------------------------------------------------------------------------
  // Pass-through: the decoder only observes the stream
  // --------------------------------------------------------------------------
  assign dout.data          = din.data;
  assign dout.startofpacket = din.startofpacket;
  assign dout.endofpacket   = din.endofpacket;
  assign dout.valid         = din.valid;
  assign din.ready          = dout.ready;

  logic       beat;
  logic       sop;
  logic       eop;
  logic [3:0] sym0;
  logic [3:0] sym1;
  logic [3:0] sym2;

  assign beat = din.valid & dout.ready;
  assign sop  = din.startofpacket;
  assign eop  = din.endofpacket;
  // Only the low nibble of each symbol carries control-packet payload.
  assign sym0 = din.data[3:0];
  assign sym1 = din.data[11:8];
  assign sym2 = din.data[19:16];

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]  state_q,      state_d;
  logic [1:0]  pay_cnt_q,    pay_cnt_d;     // control payload beats seen, saturates at 3
  logic [15:0] w_acc_q,      w_acc_d;       // width being assembled
  logic [15:0] h_acc_q,      h_acc_d;       // height being assembled
  logic [3:0]  il_acc_q,     il_acc_d;      // interlace being assembled
  logic [15:0] width_q,      width_d;
  logic [15:0] height_q,     height_d;
  logic [3:0]  il_q,         il_d;
  logic [15:0] count_q,      count_d;
  logic        ctrl_update_q, ctrl_update_d;
  logic        ctrl_err_q,    ctrl_err_d;
  logic        frame_done_q,  frame_done_d;
  // One beat can end two video packets: an abort followed by a header-only
  // packet. Each of them counts.
  logic [1:0]  evts;
`ifdef AVST_FRAME_CHECK_EN
  logic        frame_err_q,   frame_err_d;
  logic [31:0] pix_cnt_q,     pix_cnt_d;
  logic [31:0] pixels_q,      pixels_d;     // committed width*height
  logic [31:0] pix_nx;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    pay_cnt_d     = pay_cnt_q;
    w_acc_d       = w_acc_q;
    h_acc_d       = h_acc_q;
    il_acc_d      = il_acc_q;
    width_d       = width_q;
    height_d      = height_q;
    il_d          = il_q;
    ctrl_update_d = 1'b0;
    ctrl_err_d    = 1'b0;
    frame_done_d  = 1'b0;
    evts          = 2'd0;
`ifdef AVST_FRAME_CHECK_EN
    frame_err_d   = 1'b0;
    pix_cnt_d     = pix_cnt_q;
    pixels_d      = pixels_q;
    pix_nx        = (pix_cnt_q == 32'hFFFF_FFFF) ? pix_cnt_q : pix_cnt_q + 32'd1;
`endif

    if (beat) begin
      if (sop) begin
        // A new SOP terminates any packet still open.
        if (state_q == S_CTRL) begin
          ctrl_err_d = 1'b1;
        end
        if (state_q == S_VIDEO) begin
`ifdef AVST_FRAME_CHECK_EN
          frame_err_d  = 1'b1;
`else
          frame_done_d = 1'b1;
`endif
          evts = evts + 2'd1;
        end

        case (sop ? sym0 : 4'h0)
          HDR_CTRL: begin
            pay_cnt_d = 2'd0;
            if (eop) begin
              // Header-only control packet carries no geometry.
              ctrl_err_d = 1'b1;
              state_d    = S_IDLE;
            end else begin
              state_d    = S_CTRL;
            end
          end
          HDR_VIDEO: begin
`ifdef AVST_FRAME_CHECK_EN
            pix_cnt_d = 32'd0;
`endif
            if (eop) begin
              // Header-only video packet: zero pixels never match a
              // committed non-zero geometry.
`ifdef AVST_FRAME_CHECK_EN
              frame_err_d  = 1'b1;
`else
              frame_done_d = 1'b1;
`endif
              evts    = evts + 2'd1;
              state_d = S_IDLE;
            end else begin
              state_d = S_VIDEO;
            end
          end
          default: begin
            state_d = eop ? S_IDLE : S_SKIP;
          end
        endcase
      end else begin
        case (state_q)
          S_CTRL: begin
            case (pay_cnt_q)
              2'd0: begin
                w_acc_d = {sym0, sym1, sym2, w_acc_q[3:0]};
              end
              2'd1: begin
                w_acc_d = {w_acc_q[15:4], sym0};
                h_acc_d = {sym1, sym2, h_acc_q[7:0]};
              end
              2'd2: begin
                h_acc_d  = {h_acc_q[15:8], sym0, sym1};
                il_acc_d = sym2;
              end
              default: begin
                // Payload beats after the third carry nothing.
              end
            endcase
            if (pay_cnt_q != 2'd3) begin
              pay_cnt_d = pay_cnt_q + 2'd1;
            end
            if (eop) begin
              state_d = S_IDLE;
              // Judge on the next-state values so that an EOP on payload
              // beat 3 commits that beat's nibbles.
              if ((pay_cnt_d == 2'd3) && (w_acc_d != 16'd0) && (h_acc_d != 16'd0)) begin
                width_d       = w_acc_d;
                height_d      = h_acc_d;
                il_d          = il_acc_d;
                ctrl_update_d = 1'b1;
`ifdef AVST_FRAME_CHECK_EN
                pixels_d      = 32'(w_acc_d) * 32'(h_acc_d);
`endif
              end else begin
                ctrl_err_d    = 1'b1;
              end
            end
          end
          S_VIDEO: begin
`ifdef AVST_FRAME_CHECK_EN
            pix_cnt_d = pix_nx;
`endif
            if (eop) begin
`ifdef AVST_FRAME_CHECK_EN
              if (pix_nx == pixels_q) begin
                frame_done_d = 1'b1;
              end else begin
                frame_err_d  = 1'b1;
              end
`else
              frame_done_d = 1'b1;
`endif
              evts    = evts + 2'd1;
              state_d = S_IDLE;
            end
          end
          S_SKIP: begin
            if (eop) begin
              state_d = S_IDLE;
            end
          end
          default: begin
            // Beats outside a packet are ignored until the next SOP.
          end
        endcase
      end
    end

    count_d = count_q + {14'd0, evts};
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pay_cnt_q     <= 2'd0;
      w_acc_q       <= 16'd0;
      h_acc_q       <= 16'd0;
      il_acc_q      <= 4'd0;
      width_q       <= RST_WIDTH;
      height_q      <= RST_HEIGHT;
      il_q          <= 4'd0;
      count_q       <= 16'd0;
      ctrl_update_q <= 1'b0;
      ctrl_err_q    <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pay_cnt_q     <= pay_cnt_d;
      w_acc_q       <= w_acc_d;
      h_acc_q       <= h_acc_d;
      il_acc_q      <= il_acc_d;
      width_q       <= width_d;
      height_q      <= height_d;
      il_q          <= il_d;
      count_q       <= count_d;
      ctrl_update_q <= ctrl_update_d;
      ctrl_err_q    <= ctrl_err_d;
      frame_done_q  <= frame_done_d;
    end
  end

`ifdef AVST_FRAME_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err_q <= 1'b0;
      pix_cnt_q   <= 32'd0;
      pixels_q    <= RST_PIXELS;
    end else begin
      frame_err_q <= frame_err_d;
      pix_cnt_q   <= pix_cnt_d;
      pixels_q    <= pixels_d;
    end
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign frame_width     = width_q;
  assign frame_height    = height_q;
  assign frame_interlace = il_q;
  assign frame_count     = count_q;
  assign ctrl_update     = ctrl_update_q;
  assign ctrl_err        = ctrl_err_q;
  assign frame_done      = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_avst_video_ctrl_packet_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_avst_video_ctrl_packet_decoder
// Description : Self-checking bench for avst_video_ctrl_packet_decoder.
//               A packet-level reference model collects whole packets and
//               evaluates them when they end. It pushes the expected status
//               record into a queue. A monitor pops and compares the record
//               whenever the DUT raises a status pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avst_video_ctrl_packet_decoder;

  logic        clk;
  logic        reset;
  logic [15:0] frame_width;
  logic [15:0] frame_height;
  logic [3:0]  frame_interlace;
  logic        ctrl_update;
  logic        ctrl_err;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] frame_count;

  avst_video_ctrl_packet_decoder_if din_if ();
  avst_video_ctrl_packet_decoder_if dout_if ();

  avst_video_ctrl_packet_decoder #(
    .DEFAULT_WIDTH  (640),
    .DEFAULT_HEIGHT (480)
  ) u_dut (
    .clk             (clk),
    .reset           (reset),
    .din             (din_if),
    .dout            (dout_if),
    .frame_width     (frame_width),
    .frame_height    (frame_height),
    .frame_interlace (frame_interlace),
    .ctrl_update     (ctrl_update),
    .ctrl_err        (ctrl_err),
    .frame_done      (frame_done),
    .frame_err       (frame_err),
    .frame_count     (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: whole-packet evaluation
  // --------------------------------------------------------------------------
  typedef struct {
    int          cyc;
    logic [3:0]  pulses;   // {ctrl_update, ctrl_err, frame_done, frame_err}
    logic [15:0] w;
    logic [15:0] h;
    logic [3:0]  il;
    logic [15:0] cnt;
  } rec_t;

  rec_t        exp_q[$];
  logic [23:0] pkt[$];
  bit          in_pkt;
  logic [15:0] m_w, m_h, m_count;
  logic [3:0]  m_il;
  bit          ev_upd, ev_cerr, ev_done, ev_ferr;

  task automatic model_reset();
    in_pkt  = 1'b0;
    pkt.delete();
    m_w     = 16'd640;
    m_h     = 16'd480;
    m_il    = 4'd0;
    m_count = 16'd0;
  endtask

  task automatic finish_pkt(input bit aborted);
    logic [3:0]  t;
    logic [15:0] w, h;
    t = pkt[0][3:0];
    if (t == 4'hF) begin
      if (aborted || pkt.size() < 4) begin
        ev_cerr = 1'b1;
      end else begin
        w = {pkt[1][3:0], pkt[1][11:8], pkt[1][19:16], pkt[2][3:0]};
        h = {pkt[2][11:8], pkt[2][19:16], pkt[3][3:0], pkt[3][11:8]};
        if (w == 16'd0 || h == 16'd0) begin
          ev_cerr = 1'b1;
        end else begin
          m_w    = w;
          m_h    = h;
          m_il   = pkt[3][19:16];
          ev_upd = 1'b1;
        end
      end
    end else if (t == 4'h0) begin
`ifdef AVST_FRAME_CHECK_EN
      if (!aborted && (int'(pkt.size()) - 1) == int'(m_w) * int'(m_h)) ev_done = 1'b1;
      else ev_ferr = 1'b1;
`else
      ev_done = 1'b1;
`endif
      m_count = m_count + 16'd1;
    end
  endtask

  task automatic model_beat(input logic [23:0] d, input logic s, input logic e);
    rec_t r;
    ev_upd = 0; ev_cerr = 0; ev_done = 0; ev_ferr = 0;
    if (s) begin
      if (in_pkt) finish_pkt(1'b1);
      pkt.delete();
      pkt.push_back(d);
      in_pkt = 1'b1;
      if (e) begin
        finish_pkt(1'b0);
        in_pkt = 1'b0;
      end
    end else if (in_pkt) begin
      pkt.push_back(d);
      if (e) begin
        finish_pkt(1'b0);
        in_pkt = 1'b0;
      end
    end
    if (ev_upd || ev_cerr || ev_done || ev_ferr) begin
      r.cyc    = cyc;
      r.pulses = {ev_upd, ev_cerr, ev_done, ev_ferr};
      r.w      = m_w;
      r.h      = m_h;
      r.il     = m_il;
      r.cnt    = m_count;
      exp_q.push_back(r);
    end
  endtask

  // The model advances on the same edge as the DUT.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      model_reset();
      exp_q.delete();
    end else begin
      chk("pass_data", 64'(dout_if.data), 64'(din_if.data));
      chk("pass_ctl", 64'({dout_if.startofpacket, dout_if.endofpacket, dout_if.valid, din_if.ready}),
          64'({din_if.startofpacket, din_if.endofpacket, din_if.valid, dout_if.ready}));
      if (din_if.valid && dout_if.ready)
        model_beat(din_if.data, din_if.startofpacket, din_if.endofpacket);
    end
  end

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  rec_t mr;
  always @(negedge clk) begin
    if (!reset) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mr = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_pulse got none required %b at cycle %0d", mr.pulses, mr.cyc);
      end
      if (ctrl_update || ctrl_err || frame_done || frame_err) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse got %b required none at cycle %0d",
                   {ctrl_update, ctrl_err, frame_done, frame_err}, cyc);
        end else begin
          mr = exp_q.pop_front();
          chk("pulses", 64'({ctrl_update, ctrl_err, frame_done, frame_err}), 64'(mr.pulses));
          chk("geom_count", 64'({frame_width, frame_height, frame_interlace, frame_count}),
              64'({mr.w, mr.h, mr.il, mr.cnt}));
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver
  // --------------------------------------------------------------------------
  int          rdy_mode = 0;   // 0 always ready, 1 random, 2 toggle
  bit          gap_en   = 1'b0;
  logic [23:0] txq[$];

  task automatic drive_beat(input logic [23:0] d, input logic s, input logic e);
    int guard;
    if (gap_en && $urandom_range(0, 3) == 0) begin
      din_if.valid         = 1'b0;
      din_if.data          = 24'($urandom);
      din_if.startofpacket = 1'($urandom);
      din_if.endofpacket   = 1'($urandom);
      dout_if.ready        = 1'($urandom);
      @(negedge clk);
    end
    din_if.valid         = 1'b1;
    din_if.data          = d;
    din_if.startofpacket = s;
    din_if.endofpacket   = e;
    guard = 0;
    forever begin
      case (rdy_mode)
        0:       dout_if.ready = 1'b1;
        1:       dout_if.ready = ($urandom_range(0, 3) != 0);
        default: dout_if.ready = ~dout_if.ready;
      endcase
      @(posedge clk);
      if (dout_if.ready) break;
      guard++;
      if (guard > 200) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout got no beat required one within 200 cycles");
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    din_if.valid         = 1'b0;
    din_if.startofpacket = 1'b0;
    din_if.endofpacket   = 1'b0;
    dout_if.ready        = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_txq(input bit abort);
    for (int i = 0; i < txq.size(); i++)
      drive_beat(txq[i], (i == 0), (i == txq.size() - 1) && !abort);
  endtask

  task automatic send_video(input int npix, input bit abort);
    txq.delete();
    txq.push_back(24'h000000);
    for (int i = 0; i < npix; i++) txq.push_back(24'($urandom));
    send_txq(abort);
  endtask

  task automatic send_ctrl_4x2();
    txq = '{24'h00000F, 24'h000000, 24'h000004, 24'h000200};
    send_txq(1'b0);
  endtask

  task automatic send_ctrl_640x480();
    txq = '{24'h00000F, 24'h080200, 24'h010000, 24'h03000E};
    send_txq(1'b0);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  logic [15:0] r_w, r_h;
  logic [3:0]  r_il;
  logic [23:0] r_b;
  int          plen, base, npix, kind;
  bit          abort;

  initial begin
    reset                = 1'b1;
    din_if.valid         = 1'b0;
    din_if.data          = 24'd0;
    din_if.startofpacket = 1'b0;
    din_if.endofpacket   = 1'b0;
    dout_if.ready        = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_width",  64'(frame_width),  64'(640));
    chk("rst_height", 64'(frame_height), 64'(480));
    chk("rst_il",     64'(frame_interlace), 64'(0));
    chk("rst_count",  64'(frame_count),  64'(0));
    chk("rst_pulses", 64'({ctrl_update, ctrl_err, frame_done, frame_err}), 64'(0));
    idle(2);

    // 640x480 interlace 3
    send_ctrl_640x480();
    idle(2);
    chk("c1_width",  64'(frame_width),  64'(640));
    chk("c1_height", 64'(frame_height), 64'(480));
    chk("c1_il",     64'(frame_interlace), 64'(3));

    // 4x2 then exact and short frames
    send_ctrl_4x2();
    idle(2);
    chk("c2_width",  64'(frame_width),  64'(4));
    chk("c2_height", 64'(frame_height), 64'(2));
    send_video(8, 1'b0);
    idle(2);
    chk("v8_count", 64'(frame_count), 64'(1));
    send_video(7, 1'b0);
    idle(2);
    chk("v7_count", 64'(frame_count), 64'(2));

    // Short control packet leaves the geometry alone
    txq = '{24'h00000F, 24'h080200};
    send_txq(1'b0);
    idle(2);
    chk("short_width",  64'(frame_width),  64'(4));
    chk("short_height", 64'(frame_height), 64'(2));

    // Video aborted by a control SOP; the control packet still decodes
    send_video(3, 1'b1);
    send_ctrl_640x480();
    idle(2);
    chk("abort_count",  64'(frame_count),  64'(3));
    chk("abort_width",  64'(frame_width),  64'(640));
    chk("abort_height", 64'(frame_height), 64'(480));
    send_ctrl_4x2();

    // Back-pressure toggling on a 4x2 frame
    rdy_mode = 2;
    send_video(8, 1'b0);
    rdy_mode = 0;
    idle(2);
    chk("stall_count", 64'(frame_count), 64'(4));

    // Reset during control payload beat 2
    drive_beat(24'h00000F, 1'b1, 1'b0);
    drive_beat(24'h080200, 1'b0, 1'b0);
    din_if.valid         = 1'b1;
    din_if.data          = 24'h010000;
    din_if.startofpacket = 1'b0;
    din_if.endofpacket   = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_width",  64'(frame_width),  64'(640));
    chk("mid_rst_height", 64'(frame_height), 64'(480));
    chk("mid_rst_il",     64'(frame_interlace), 64'(0));
    chk("mid_rst_count",  64'(frame_count),  64'(0));
    drive_beat(24'h03000E, 1'b0, 1'b1);   // tail of the interrupted packet
    idle(2);
    chk("tail_width", 64'(frame_width), 64'(640));
    send_ctrl_4x2();
    idle(2);
    chk("post_rst_width",  64'(frame_width),  64'(4));
    chk("post_rst_height", 64'(frame_height), 64'(2));
    txq = '{24'h000003, 24'h123456, 24'hABCDEF};
    send_txq(1'b0);
    idle(2);
    chk("type3_width", 64'(frame_width), 64'(4));

    // Randomized traffic
    gap_en   = 1'b1;
    rdy_mode = 1;
    for (int n = 0; n < 150; n++) begin
      kind  = $urandom_range(0, 9);
      abort = (n != 149) && ($urandom_range(0, 7) == 0);
      txq.delete();
      if (kind < 3) begin
        r_w  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 8));
        r_h  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 4));
        r_il = 4'($urandom);
        plen = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : 3;
        r_b = 24'($urandom);
        r_b[3:0] = 4'hF;
        txq.push_back(r_b);
        for (int i = 0; i < plen; i++) begin
          r_b = 24'($urandom);
          case (i)
            0: begin r_b[3:0] = r_w[15:12]; r_b[11:8] = r_w[11:8];  r_b[19:16] = r_w[7:4];  end
            1: begin r_b[3:0] = r_w[3:0];   r_b[11:8] = r_h[15:12]; r_b[19:16] = r_h[11:8]; end
            2: begin r_b[3:0] = r_h[7:4];   r_b[11:8] = r_h[3:0];   r_b[19:16] = r_il;      end
            default: ;
          endcase
          txq.push_back(r_b);
        end
      end else if (kind < 8) begin
        base = int'(m_w) * int'(m_h);
        if (base > 64) base = 8;
        npix = base;
        if ($urandom_range(0, 3) == 0) npix = base + $urandom_range(0, 2) - 1;
        if ($urandom_range(0, 15) == 0) npix = 0;
        if (npix < 0) npix = 0;
        r_b = 24'($urandom);
        r_b[3:0] = 4'h0;
        txq.push_back(r_b);
        for (int i = 0; i < npix; i++) txq.push_back(24'($urandom));
      end else begin
        r_b = 24'($urandom);
        r_b[3:0] = 4'($urandom_range(1, 14));
        txq.push_back(r_b);
        plen = $urandom_range(0, 3);
        for (int i = 0; i < plen; i++) txq.push_back(24'($urandom));
      end
      send_txq(abort);
      if (!abort && $urandom_range(0, 7) == 0)
        drive_beat(24'($urandom), 1'b0, 1'($urandom));
    end
    idle(5);
    chk("model_count", 64'(frame_count), 64'(m_count));
    chk("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL global_timeout got running required finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
